stack_ctrl_fsm: RTL and testbench
=================================

// Module: stack_ctrl_fsm
// PURPOSE
//  Multicycle sequencer for the STACK_CPU datapath. Fetches 32-bit words from instruction memory,
//  decodes opcode [31:26], and drives the stack RAM and stack pointer for NOP/PUSH/POP/ADD.
//  Detects overflow, underflow and illegal opcodes, and halts on any of them.
//  Sits between imem and the stack RAM; the top-level CPU only adds the memories around it.
// PARAMETERS
//  DATA_W  32  stack word width; PUSH immediate [15:0] is zero-extended to DATA_W
//  DEPTH   16  stack entries; power of two, >=2; SP width = $clog2(DEPTH)+1
//  PC_W    8   program counter width; wraps modulo 2**PC_W
// PORTS
//  clock       in   1         rising-edge clock
//  reset       in   1         synchronous, active-high
//  pc          out  PC_W      instruction address; imem read is combinational (instr valid same cycle)
//  instr       in   32        instruction word at pc
//  st_addr     out  SPW-1     stack RAM address (SPW = $clog2(DEPTH)+1)
//  st_we       out  1         stack RAM write strobe
//  st_wdata    out  DATA_W    stack RAM write data
//  st_rdata    in   DATA_W    stack RAM read data, valid 1 cycle after st_addr (synchronous read)
//  sp          out  SPW       entries on the stack (0..DEPTH)
//  pop_valid   out  1         1-cycle pulse: pop_data holds the value just popped
//  pop_data    out  DATA_W    last popped value; holds until the next POP
//  halted      out  1         sticky fault indication
//  fault_code  out  2         00 none, 01 overflow, 10 underflow, 11 illegal opcode
// BEHAVIOUR
//  Opcodes [31:26]: 000000 NOP, 000001 PUSH imm16, 000010 POP, 000011 ADD; all others illegal.
//  Reset: pc=0, sp=0, st_we=0, st_addr=0, st_wdata=0, pop_valid=0, pop_data=0, halted=0,
//    fault_code=00, state=FETCH. RAM contents are untouched. Reset in any state (HALT included)
//    aborts the operation in flight; no write is issued in the reset cycle.
//  States: FETCH, DECODE, POP_WAIT, ADD_RD2, ADD_EX, HALT.
//  FETCH: IR<=instr; pc<=pc+1 -> DECODE.
//  DECODE:
//    NOP -> FETCH.
//    PUSH: if sp==DEPTH -> HALT, code 01, no write.
//      Else st_we=1, st_addr=sp, st_wdata=imm; sp<=sp+1 -> FETCH.
//    POP: if sp==0 -> HALT, code 10.
//      Else st_addr=sp-1; sp<=sp-1 -> POP_WAIT.
//    ADD: if sp<2 -> HALT, code 10, sp unchanged.
//      Else st_addr=sp-1 -> ADD_RD2.
//    Illegal -> HALT, code 11.
//  POP_WAIT: pop_data<=st_rdata, pop_valid=1 -> FETCH.
//  ADD_RD2: A<=st_rdata; st_addr=sp-2 -> ADD_EX.
//  ADD_EX: st_we=1, st_addr=sp-2, st_wdata=A+st_rdata (mod 2**DATA_W, carry discarded);
//    sp<=sp-1 -> FETCH.
//  HALT: no RAM writes; pc and sp frozen; stays until reset.
//  Latency per instruction, FETCH to next FETCH: NOP 2, PUSH 2, POP 3, ADD 4 cycles.
//  st_we is asserted only in DECODE(PUSH) and ADD_EX, and for exactly one cycle.
//  The fault check happens in DECODE before any side effect; a faulting instruction leaves
//    sp and RAM unchanged. pc has already advanced past the faulting word.
//  Boundaries:
//    PUSH at sp==DEPTH-1 succeeds (sp->DEPTH); the next PUSH faults.
//    POP at sp==1 succeeds (sp->0).
//    ADD at sp==2 succeeds (sp->1).
//    pc wraps from 2**PC_W-1 to 0 silently.
// TESTING
//  1 Program: PUSH 11,22,33,44,55; NOP; ADD; NOP; POP x4; NOP ->
//    after ADD sp=4, RAM[3]=0x99; pops give 0x99,0x33,0x22,0x11 (pop_valid pulses);
//    final sp=0, halted=0.
//  2 DEPTH=16: 17 PUSH 0x1..0x11 ->
//    sp=16 after the 16th; on the 17th halted=1, code 01, RAM[15]=0x10, no st_we;
//    pc frozen at 17.
//  3 Reset, then POP ->
//    halted=1, code 10, sp=0, no pop_valid.
//    Separately: PUSH 7 then ADD -> code 10, sp=1.
//  4 PUSH FFFF; PUSH 1; ADD; POP on DATA_W=16 ->
//    pop_data=0x0000 (wrap). On DATA_W=32: 0x00010000.
//  5 Word 0xFC000000 -> halted=1, code 11.
//    Assert reset 1 cycle -> all outputs at reset values; the program restarts at pc=0.
//  6 Assert reset in ADD_RD2 mid-ADD ->
//    no st_we issued; sp=0 next cycle; state FETCH.
//    Cycle counts checked: NOP 2, PUSH 2, POP 3, ADD 4.

Source files
------------

// File: rtl/stack_ctrl_fsm.sv
// Multicycle sequencer for the STACK_CPU datapath: fetches and decodes NOP/PUSH/POP/ADD
// and drives the stack RAM and stack pointer. It halts on overflow, underflow or an illegal opcode.
module stack_ctrl_fsm #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int PC_W    = 8,
    localparam int SPW    = $clog2(DEPTH) + 1,
    localparam int AW     = SPW - 1
) (
    input  logic              clock,
    input  logic              reset,
    output logic [PC_W-1:0]   pc,
    input  logic [31:0]       instr,
    output logic [AW-1:0]     st_addr,
    output logic              st_we,
    output logic [DATA_W-1:0] st_wdata,
    input  logic [DATA_W-1:0] st_rdata,
    output logic [SPW-1:0]    sp,
    output logic              pop_valid,
    output logic [DATA_W-1:0] pop_data,
    output logic              halted,
    output logic [1:0]        fault_code
);

    // state      | meaning
    // S_FETCH    | latch instr into IR, advance pc
    // S_DECODE   | fault check, then PUSH write / POP read / ADD first read
    // S_POP_WAIT | RAM read data arrives, capture into pop_data
    // S_ADD_RD2  | capture top operand, read second operand
    // S_ADD_EX   | write the sum over the second operand, drop sp
    // S_HALT     | faulted; frozen until reset
    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_POP_WAIT,
        S_ADD_RD2,
        S_ADD_EX,
        S_HALT
    } state_t;

    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_PUSH = 6'd1;
    localparam logic [5:0] OP_POP  = 6'd2;
    localparam logic [5:0] OP_ADD  = 6'd3;

    localparam logic [1:0] F_OVF = 2'b01;
    localparam logic [1:0] F_UNF = 2'b10;
    localparam logic [1:0] F_ILL = 2'b11;

    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
    localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
    localparam logic [SPW-1:0] SP_TWO  = SPW'(2);

    state_t              state, state_nxt;
    logic [31:0]         ir, ir_nxt;
    logic [DATA_W-1:0]   a_reg, a_nxt;
    logic [PC_W-1:0]     pc_nxt;
    logic [SPW-1:0]      sp_nxt;
    logic [DATA_W-1:0]   pop_data_nxt;
    logic                pop_valid_nxt;
    logic [1:0]          fault_nxt;
    logic [5:0]          opcode;
    logic [DATA_W-1:0]   imm_ext;
    logic                unused_ir;

    assign opcode    = ir[31:26];
    assign imm_ext   = DATA_W'(ir[15:0]);
    assign unused_ir = &{1'b0, ir[25:16]};
    assign halted    = (state == S_HALT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_FETCH;
            pc         <= '0;
            sp         <= '0;
            ir         <= '0;
            a_reg      <= '0;
            pop_data   <= '0;
            pop_valid  <= 1'b0;
            fault_code <= 2'b00;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            sp         <= sp_nxt;
            ir         <= ir_nxt;
            a_reg      <= a_nxt;
            pop_data   <= pop_data_nxt;
            pop_valid  <= pop_valid_nxt;
            fault_code <= fault_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        sp_nxt        = sp;
        ir_nxt        = ir;
        a_nxt         = a_reg;
        pop_data_nxt  = pop_data;
        pop_valid_nxt = 1'b0;
        fault_nxt     = fault_code;
        st_we         = 1'b0;
        st_addr       = '0;
        st_wdata      = '0;

        unique case (state)
            S_FETCH: begin
                ir_nxt    = instr;
                pc_nxt    = pc + PC_W'(1);
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                // Fault checks come first so a faulting word leaves sp and RAM untouched.
                case (opcode)
                    OP_NOP: state_nxt = S_FETCH;
                    OP_PUSH: begin
                        if (sp == SP_FULL) begin
                            fault_nxt = F_OVF;
                            state_nxt = S_HALT;
                        end else begin
                            st_we     = 1'b1;
                            st_addr   = AW'(sp);
                            st_wdata  = imm_ext;
                            sp_nxt    = sp + SP_ONE;
                            state_nxt = S_FETCH;
                        end
                    end
                    OP_POP: begin
                        if (sp == '0) begin
                            fault_nxt = F_UNF;
                            state_nxt = S_HALT;
                        end else begin
                            st_addr   = AW'(sp - SP_ONE);
                            sp_nxt    = sp - SP_ONE;
                            state_nxt = S_POP_WAIT;
                        end
                    end
                    OP_ADD: begin
                        if (sp < SP_TWO) begin
                            fault_nxt = F_UNF;
                            state_nxt = S_HALT;
                        end else begin
                            st_addr   = AW'(sp - SP_ONE);
                            state_nxt = S_ADD_RD2;
                        end
                    end
                    default: begin
                        fault_nxt = F_ILL;
                        state_nxt = S_HALT;
                    end
                endcase
            end
            S_POP_WAIT: begin
                pop_data_nxt  = st_rdata;
                pop_valid_nxt = 1'b1;
                state_nxt     = S_FETCH;
            end
            S_ADD_RD2: begin
                a_nxt     = st_rdata;
                st_addr   = AW'(sp - SP_TWO);
                state_nxt = S_ADD_EX;
            end
            S_ADD_EX: begin
                st_we     = 1'b1;
                st_addr   = AW'(sp - SP_TWO);
                st_wdata  = a_reg + st_rdata;
                sp_nxt    = sp - SP_ONE;
                state_nxt = S_FETCH;
            end
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase

        // The RAM strobe is combinational, so the reset cycle must be masked explicitly.
        if (reset) begin
            st_we    = 1'b0;
            st_addr  = '0;
            st_wdata = '0;
        end
    end

endmodule

// File: tb/tb_stack_ctrl_fsm.sv
// Bench for stack_ctrl_fsm: directed vector table, hand-written corner sequences and
// random programs checked against an instruction-level stack model.
module tb_stack_ctrl_fsm;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int PC_W   = 8;
    localparam int SPW    = $clog2(DEPTH) + 1;
    localparam int AW     = SPW - 1;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [PC_W-1:0]   pc;
    logic [31:0]       instr;
    logic [AW-1:0]     st_addr;
    logic              st_we;
    logic [DATA_W-1:0] st_wdata;
    logic [DATA_W-1:0] st_rdata;
    logic [SPW-1:0]    sp;
    logic              pop_valid;
    logic [DATA_W-1:0] pop_data;
    logic              halted;
    logic [1:0]        fault_code;

    stack_ctrl_fsm #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clock(clock), .reset(reset), .pc(pc), .instr(instr),
        .st_addr(st_addr), .st_we(st_we), .st_wdata(st_wdata), .st_rdata(st_rdata),
        .sp(sp), .pop_valid(pop_valid), .pop_data(pop_data),
        .halted(halted), .fault_code(fault_code)
    );

    always #5 clock = ~clock;

    logic [31:0]       imem [256];
    logic [DATA_W-1:0] ram  [DEPTH];

    assign instr = imem[pc];

    always @(posedge clock) begin
        if (st_we) ram[st_addr] <= st_wdata;
        st_rdata <= ram[st_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] w_push(input logic [15:0] imm);
        return {6'd1, 10'd0, imm};
    endfunction
    localparam logic [31:0] W_NOP = 32'h0000_0000;
    localparam logic [31:0] W_POP = 32'h0800_0000;
    localparam logic [31:0] W_ADD = 32'h0C00_0000;

    // Instruction-level reference: the stack is a queue, one call per instruction word.
    logic [31:0] m_stk [$];
    logic [7:0]  m_pc;
    bit          m_halt;
    logic [1:0]  m_code;

    task automatic model_step(input logic [31:0] w, output int lat, output int nwr,
                              output bit popv, output logic [31:0] popd);
        logic [31:0] x, y;
        lat  = 2;
        nwr  = 0;
        popv = 0;
        popd = '0;
        m_pc = m_pc + 8'd1;
        case (w[31:26])
            6'd0: ;
            6'd1: begin
                if (m_stk.size() == DEPTH) begin m_halt = 1; m_code = 2'b01; end
                else begin m_stk.push_back({16'h0, w[15:0]}); nwr = 1; end
            end
            6'd2: begin
                if (m_stk.size() == 0) begin m_halt = 1; m_code = 2'b10; end
                else begin popd = m_stk.pop_back(); popv = 1; lat = 3; end
            end
            6'd3: begin
                if (m_stk.size() < 2) begin m_halt = 1; m_code = 2'b10; end
                else begin
                    x = m_stk.pop_back();
                    y = m_stk.pop_back();
                    m_stk.push_back(x + y);
                    nwr = 1;
                    lat = 4;
                end
            end
            default: begin m_halt = 1; m_code = 2'b11; end
        endcase
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = W_NOP;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " rst pc"}, 32'(pc), 32'd0);
        chk({tag, " rst sp"}, 32'(sp), 32'd0);
        chk({tag, " rst st_we"}, 32'(st_we), 32'd0);
        chk({tag, " rst st_addr"}, 32'(st_addr), 32'd0);
        chk({tag, " rst st_wdata"}, st_wdata, 32'd0);
        chk({tag, " rst pop_valid"}, 32'(pop_valid), 32'd0);
        chk({tag, " rst pop_data"}, pop_data, 32'd0);
        chk({tag, " rst halted"}, 32'(halted), 32'd0);
        chk({tag, " rst fault_code"}, 32'(fault_code), 32'd0);
    endtask

    task automatic model_reset();
        m_stk.delete();
        m_pc   = 8'd0;
        m_halt = 0;
        m_code = 2'b00;
    endtask

    task automatic start(input int ncyc, input bit check_rst, input string tag);
        reset = 1'b1;
        repeat (ncyc) @(negedge clock);
        if (check_rst) check_reset_vals(tag);
        reset = 1'b0;
        model_reset();
    endtask

    // Runs one instruction for the model's latency; the first-cycle pc check of the next
    // call confirms this instruction ended exactly on its last cycle.
    task automatic exec(input string tag);
        logic [31:0] w, popd, got_pop;
        int lat, nwr, nwr_seen, pops;
        bit popv, ram_ok;
        w = imem[m_pc];
        model_step(w, lat, nwr, popv, popd);
        nwr_seen = 0;
        pops     = 0;
        got_pop  = '0;
        for (int c = 0; c < lat; c++) begin
            @(negedge clock);
            if (st_we) nwr_seen++;
            if (pop_valid) begin pops++; got_pop = pop_data; end
            if (c == 0) chk({tag, " pc"}, 32'(pc), 32'(m_pc));
        end
        chk({tag, " sp"}, 32'(sp), 32'(m_stk.size()));
        chk({tag, " halted"}, 32'(halted), 32'(m_halt));
        chk({tag, " fault_code"}, 32'(fault_code), 32'(m_code));
        chk({tag, " writes"}, 32'(nwr_seen), 32'(nwr));
        chk({tag, " pop_pulses"}, 32'(pops), popv ? 32'd1 : 32'd0);
        if (popv) chk({tag, " pop_data"}, got_pop, popd);
        ram_ok = 1;
        for (int i = 0; i < m_stk.size(); i++) if (ram[i] !== m_stk[i]) ram_ok = 0;
        chk({tag, " ram"}, 32'(ram_ok), 32'd1);
    endtask

    task automatic check_frozen(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clock);
            chk({tag, " frozen pc"}, 32'(pc), 32'(m_pc));
            chk({tag, " frozen sp"}, 32'(sp), 32'(m_stk.size()));
            chk({tag, " frozen st_we"}, 32'(st_we), 32'd0);
            chk({tag, " frozen halted"}, 32'(halted), 32'd1);
        end
    endtask

    typedef struct {
        logic [31:0] word;
        int          exp_sp;
        bit          exp_popv;
        logic [31:0] exp_pop;
    } vec_t;

    vec_t t1 [13];

    initial begin
        int edges [$];
        int exp_int [6];
        logic [PC_W-1:0] prev_pc;
        logic [31:0] lo;
        int r, bias;

        t1[0]  = '{w_push(16'h11), 1, 0, 32'h0};
        t1[1]  = '{w_push(16'h22), 2, 0, 32'h0};
        t1[2]  = '{w_push(16'h33), 3, 0, 32'h0};
        t1[3]  = '{w_push(16'h44), 4, 0, 32'h0};
        t1[4]  = '{w_push(16'h55), 5, 0, 32'h0};
        t1[5]  = '{W_NOP,          5, 0, 32'h0};
        t1[6]  = '{W_ADD,          4, 0, 32'h0};
        t1[7]  = '{W_NOP,          4, 0, 32'h0};
        t1[8]  = '{W_POP,          3, 1, 32'h99};
        t1[9]  = '{W_POP,          2, 1, 32'h33};
        t1[10] = '{W_POP,          1, 1, 32'h22};
        t1[11] = '{W_POP,          0, 1, 32'h11};
        t1[12] = '{W_NOP,          0, 0, 32'h0};

        for (int i = 0; i < DEPTH; i++) ram[i] = '0;
        clear_imem();

        // Vector table: canonical program
        for (int i = 0; i < 13; i++) imem[i] = t1[i].word;
        start(2, 1, "t1");
        for (int i = 0; i < 13; i++) begin
            exec("t1");
            chk("t1 table sp", 32'(sp), 32'(t1[i].exp_sp));
            if (t1[i].exp_popv) chk("t1 table pop", pop_data, t1[i].exp_pop);
            if (i == 6) chk("t1 ram3 sum", ram[3], 32'h99);
        end
        chk("t1 final halted", 32'(halted), 32'd0);

        // Overflow on the 17th push
        clear_imem();
        for (int i = 0; i < 17; i++) imem[i] = w_push(16'(i + 1));
        start(2, 0, "t2");
        for (int i = 0; i < 17; i++) begin
            exec("t2");
            if (i == 15) chk("t2 sp full", 32'(sp), 32'd16);
        end
        chk("t2 code", 32'(fault_code), 32'd1);
        chk("t2 ram15", ram[15], 32'h10);
        chk("t2 pc", 32'(pc), 32'd17);
        check_frozen("t2", 3);

        // Underflow: POP on empty, ADD with one entry
        clear_imem();
        imem[0] = W_POP;
        start(2, 0, "t3a");
        exec("t3a");
        chk("t3a code", 32'(fault_code), 32'd2);
        chk("t3a sp", 32'(sp), 32'd0);
        check_frozen("t3a", 2);
        clear_imem();
        imem[0] = w_push(16'd7);
        imem[1] = W_ADD;
        start(2, 0, "t3b");
        exec("t3b");
        exec("t3b");
        chk("t3b code", 32'(fault_code), 32'd2);
        chk("t3b sp", 32'(sp), 32'd1);

        // Carry out of the immediate range
        clear_imem();
        imem[0] = w_push(16'hFFFF);
        imem[1] = w_push(16'h0001);
        imem[2] = W_ADD;
        imem[3] = W_POP;
        start(2, 0, "t4");
        for (int i = 0; i < 4; i++) exec("t4");
        chk("t4 pop sum", pop_data, 32'h0001_0000);

        // Illegal opcode, then one-cycle reset restarts at pc 0
        clear_imem();
        imem[0] = 32'hFC00_0000;
        start(2, 0, "t5");
        exec("t5");
        chk("t5 halted", 32'(halted), 32'd1);
        chk("t5 code", 32'(fault_code), 32'd3);
        start(1, 1, "t5");
        @(negedge clock);
        chk("t5 restart pc", 32'(pc), 32'd1);

        // Reset mid-ADD and reset during a PUSH decode
        clear_imem();
        imem[0] = w_push(16'd1);
        imem[1] = w_push(16'd2);
        imem[2] = W_ADD;
        start(2, 0, "t6");
        exec("t6");
        exec("t6");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1 chk("t6 we rd2", 32'(st_we), 32'd0);
        @(negedge clock);
        chk("t6 we abort", 32'(st_we), 32'd0);
        chk("t6 sp abort", 32'(sp), 32'd0);
        chk("t6 pc abort", 32'(pc), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("t6 fetch pc", 32'(pc), 32'd1);
        chk("t6 ram0 kept", ram[0], 32'd1);
        clear_imem();
        imem[0] = w_push(16'd5);
        start(2, 0, "t6b");
        @(negedge clock);
        chk("t6b we decode", 32'(st_we), 32'd1);
        reset = 1'b1;
        #1 chk("t6b we masked", 32'(st_we), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("t6b ram0 kept", ram[0], 32'd1);

        // Latency: NOP 2, PUSH 2, POP 3, PUSH 2, PUSH 2, ADD 4
        clear_imem();
        imem[0] = W_NOP;
        imem[1] = w_push(16'd3);
        imem[2] = W_POP;
        imem[3] = w_push(16'd1);
        imem[4] = w_push(16'd2);
        imem[5] = W_ADD;
        exp_int = '{2, 2, 3, 2, 2, 4};
        start(2, 0, "t7");
        prev_pc = '0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clock);
            if (pc != prev_pc) edges.push_back(c);
            prev_pc = pc;
        end
        chk("t7 fetch count", 32'(edges.size() >= 7), 32'd1);
        if (edges.size() >= 7)
            for (int i = 0; i < 6; i++)
                chk("t7 latency", 32'(edges[i+1] - edges[i]), 32'(exp_int[i]));

        // pc wrap after 257 NOPs
        clear_imem();
        start(2, 0, "t8");
        repeat (2 * 257) @(negedge clock);
        chk("t8 pc wrap", 32'(pc), 32'd1);
        chk("t8 halted", 32'(halted), 32'd0);

        // Random programs against the model
        for (int p = 0; p < 24; p++) begin
            clear_imem();
            bias = (p % 2 == 0) ? 45 : 75;
            for (int i = 0; i < 30; i++) begin
                lo = $urandom;
                r  = $urandom_range(0, 99);
                if (r < bias) imem[i] = {6'd1, lo[25:0]};
                else begin
                    r = $urandom_range(0, 19);
                    if (r < 7)       imem[i] = {6'd2, lo[25:0]};
                    else if (r < 14) imem[i] = {6'd3, lo[25:0]};
                    else if (r < 18) imem[i] = {6'd0, lo[25:0]};
                    else             imem[i] = {6'($urandom_range(4, 63)), lo[25:0]};
                end
            end
            start(2, 0, "rnd");
            for (int i = 0; i < 30 && !m_halt; i++) exec("rnd");
            if (m_halt) check_frozen("rnd", 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
